line_sum_ctrl: RTL and testbench

Parametrised sliding-window row summer for the UART matrix-sum path. It accepts a ROWS×COLS matrix streamed row-major one byte at a time from the UART receive side. For every column of every row from row WIN-1 onward, it emits the column-wise sum of the most recent WIN rows to the UART transmit side. It generalises the fixed two-FIFO, three-row controller: window depth, data width and matrix size are parameters, and the output has a valid/ready handshake with backpressure to the input.

---
 rtl/line_sum_ctrl.sv | 82 ++++++++
 tb/tb_line_sum_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/line_sum_ctrl.sv
// line_sum_ctrl: sliding-window column summer over a row-major streamed matrix
module line_sum_ctrl #(
    parameter int DATA_W = 8,
    parameter int COLS   = 5,
    parameter int ROWS   = 6,
    parameter int WIN    = 3,
    parameter int SUM_W  = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [DATA_W-1:0] hist [WIN-1][COLS];
    logic [SUM_W-1:0]  sum;
    logic              acc, last_col, last_row;

    assign in_ready = !sys_rst && (state == FILL || (state == RUN && (!out_valid || out_ready)));
    assign acc      = in_valid && in_ready;
    assign last_col = col_cnt == CW'(COLS - 1);
    assign last_row = row_cnt == RW'(ROWS - 1);

    // column sum of the incoming sample and the pre-shift history
    always_comb begin
        sum = SUM_W'(in_data);
        for (int k = 0; k < WIN - 1; k++) sum = sum + SUM_W'(hist[k][col_cnt]);
    end

    // line history shift; never cleared since FILL overwrites every entry before use
    always_ff @(posedge sys_clk)
        if (acc) begin
            hist[0][col_cnt] <= in_data;
            for (int k = 1; k < WIN - 1; k++) hist[k][col_cnt] <= hist[k-1][col_cnt];
        end

    // frame FSM, position counters and output register
    always_ff @(posedge sys_clk)
        if (sys_rst) begin
            state      <= FILL;
            col_cnt    <= '0;
            row_cnt    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (state == DONE) begin
                state   <= FILL;
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (acc) begin
                col_cnt <= last_col ? '0 : col_cnt + 1'b1;
                if (last_col) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                if (state == RUN) begin
                    out_data  <= sum;
                    out_valid <= 1'b1;
                    out_last  <= last_col && last_row;
                end
                if (state == FILL && last_col && row_cnt == RW'(WIN - 2)) state <= RUN;
                if (state == RUN && last_col && last_row) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_line_sum_ctrl.sv
// tb_line_sum_ctrl: scoreboard bench for line_sum_ctrl, default and WIN=2 builds
module tb_line_sum_ctrl;
    localparam int R = 6, C = 5, W = 3;

    logic       sys_clk = 0, sys_rst = 1;
    logic [7:0] in_data = 0, in_data2 = 0;
    logic       in_valid = 0, in_valid2 = 0, out_ready = 1, out_ready2 = 1;
    logic       in_ready, out_valid, out_last, frame_done;
    logic       in_ready2, out_valid2, out_last2, frame_done2;
    logic [9:0] out_data;
    logic [8:0] out_data2;

    typedef struct {int val; bit last;} exp_t;
    typedef struct {int nfr; int sat; int mode; int cut; int n_out; int first; int lastv;} vec_t;

    exp_t q[$];
    exp_t q2[$];
    int   mat[R][C];
    int   checks = 0, errors = 0;

    always #5 sys_clk = ~sys_clk;

    line_sum_ctrl u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done)
    );

    line_sum_ctrl #(.DATA_W(8), .COLS(3), .ROWS(4), .WIN(2), .SUM_W(9)) u_small (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .frame_done(frame_done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int total, sent, nout, ndone, stall, cyc, idle, first, lastv, r, c, f, val, s;
        bit fin_prev, done_prev, stall_prev;
        logic [9:0] held;
        exp_t e;
        total = v.cut > 0 ? v.cut : v.nfr * R * C;
        {sent, nout, ndone, stall, cyc, idle} = '0;
        first = -1; lastv = -1;
        {fin_prev, done_prev, stall_prev} = '0;
        held = '0;
        q.delete();
        while (cyc < 4000 && (sent < total || (v.cut == 0 && (q.size() > 0 || idle < 3)))) begin
            @(negedge sys_clk);
            cyc++;
            if (v.mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (v.mode == 2 && out_valid && stall < 4) begin out_ready = 0; stall++; end
            else out_ready = 1;
            f = sent / (R * C); r = (sent / C) % R; c = sent % C;
            val = v.sat ? 255 : 10 * r + c + f;
            in_valid = sent < total;
            in_data = 8'(val);
            #1;
            if (fin_prev) begin
                chk("frame_done_after_last", frame_done, 1);
                chk("in_ready_done", in_ready, 0);
            end
            if (done_prev) chk("in_ready_after_done", in_ready, 1);
            if (frame_done) ndone++;
            if (stall_prev) begin
                chk("stall_hold_data", out_data, held);
                chk("stall_hold_valid", out_valid, 1);
            end
            if (v.mode == 2 && out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_data_30", out_data, 30);
            end
            stall_prev = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_output", out_data, 32'hFFFF_FFFF);
                else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.val);
                    chk("out_last", out_last, e.last);
                end
                if (first < 0) first = int'(out_data);
                lastv = int'(out_data);
                nout++;
            end
            done_prev = frame_done;
            fin_prev = 0;
            if (in_valid && in_ready) begin
                mat[r][c] = val;
                if (r >= W - 1) begin
                    s = 0;
                    for (int k = 0; k < W; k++) s += mat[r-k][c];
                    q.push_back('{s, r == R - 1 && c == C - 1});
                end
                fin_prev = r == R - 1 && c == C - 1;
                sent++;
            end
            if (sent >= total && q.size() == 0) idle++;
        end
        in_valid = 0;
        out_ready = 1;
        if (cyc >= 4000) chk("timeout", cyc, 0);
        if (v.cut == 0) begin
            chk("n_outputs", nout, v.n_out);
            chk("n_frame_done", ndone, v.nfr);
            chk("first_output", first, v.first);
            chk("last_output", lastv, v.lastv);
            chk("queue_empty", q.size(), 0);
        end
    endtask

    task automatic run_small();
        int sent, nout, cyc, r, c;
        exp_t e;
        {sent, nout, cyc} = '0;
        q2.delete();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) q2.push_back('{20 * k + 10 + 2 * j, k == 2 && j == 2});
        while (cyc < 500 && (sent < 12 || q2.size() > 0)) begin
            @(negedge sys_clk);
            cyc++;
            r = sent / 3; c = sent % 3;
            in_valid2 = sent < 12;
            in_data2 = 8'(10 * r + c);
            #1;
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) chk("small_unexpected", out_data2, 32'hFFFF_FFFF);
                else begin
                    e = q2.pop_front();
                    chk("small_out_data", out_data2, e.val);
                    chk("small_out_last", out_last2, e.last);
                end
                nout++;
            end
            if (in_valid2 && in_ready2) sent++;
        end
        in_valid2 = 0;
        if (cyc >= 500) chk("small_timeout", cyc, 0);
        chk("small_n_outputs", nout, 9);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1, 0, 0, 0, 20, 30, 132};
        vecs[1] = '{1, 1, 0, 0, 20, 765, 765};
        vecs[2] = '{1, 0, 2, 0, 20, 30, 132};
        vecs[3] = '{1, 0, 1, 0, 20, 30, 132};
        vecs[4] = '{2, 0, 0, 0, 40, 30, 135};

        @(negedge sys_clk);
        #1 chk("rst_in_ready", in_ready, 0);
        @(negedge sys_clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        sys_rst = 0;
        #1 chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_in_ready_small", in_ready2, 1);

        for (int i = 0; i < 5; i++) run(vecs[i]);

        run('{1, 0, 0, 12, 0, 0, 0});
        @(negedge sys_clk);
        sys_rst = 1;
        #1 chk("midrst_in_ready", in_ready, 0);
        @(negedge sys_clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_frame_done", frame_done, 0);
        sys_rst = 0;
        #1 chk("midrst_release_in_ready", in_ready, 1);
        run(vecs[0]);

        run_small();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
